button_event_classifier: RTL and testbench
==========================================

Name: button_event_classifier

Overview:
- Sits directly downstream of the debounce stage. It consumes the clean, clock-synchronous button level (debounce `out`) and classifies each gesture as a short press, long press or double press.
- Also provides a held-level indicator and a wrapping press counter for the button-tester display/logging logic.
- Pure sequential block: one FSM, one shared cycle timer, one press counter.

Parameters:
- TIMER_SIZE, 16, width of the shared cycle timer.
- LONG_LIMIT, 16'd1000, consecutive high cycles in PRESS1 that make a long press; must be ≥1 and fit in TIMER_SIZE.
- DOUBLE_WINDOW, 16'd300, cycles after a short release during which a second press counts as a double press; must be ≥1 and fit in TIMER_SIZE.
- COUNT_SIZE, 8, width of press_count.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  1  debounced button level (1 = pressed), already synchronous to clock.
- short_press  output  1  one-cycle pulse: single short press classified.
- long_press  output  1  one-cycle pulse: press held for LONG_LIMIT cycles.
- double_press  output  1  one-cycle pulse: second press released inside the window.
- held  output  1  registered copy of in (1-cycle latency).
- press_count  output  COUNT_SIZE  number of rising edges of in; wraps modulo 2^COUNT_SIZE.

Behaviour:
- Reset (synchronous, active-high; one clock, synchronous, active-high reset):
  - State ← IDLE, timer ← 0, in_q ← 0.
  - short_press, long_press, double_press, held ← 0; press_count ← 0.
  - A mid-gesture reset abandons the gesture with no pulse.
  - Reset has priority over every other event.
- Signals:
  - in_q = registered in; held = in_q.
  - Rising edge = in & ~in_q. Each rising edge increments press_count on that clock; all-ones wraps to 0.
- Outputs: all pulses are registered. Each is high for exactly one cycle, the cycle after the clock edge on which its condition was sampled. At most one pulse is high in any cycle.
- FSM (the timer clears to 0 on every state change):
  - IDLE:
    - in=1 → PRESS1.
  - PRESS1:
    - in=0 → WAIT2.
    - in=1 and timer==LONG_LIMIT-1 → long_press pulse, go to LONG_HELD.
    - Otherwise timer+1.
  - LONG_HELD:
    - in=0 → IDLE. No further pulses for this press.
  - WAIT2:
    - in=1 → PRESS2. Press wins if this coincides with timer==DOUBLE_WINDOW-1.
    - Else timer==DOUBLE_WINDOW-1 → short_press pulse, go to IDLE.
    - Otherwise timer+1.
  - PRESS2:
    - in=0 → double_press pulse, go to IDLE.
    - The duration of the second press is not timed; holding it never produces long_press.
- Timer: counts only in PRESS1 and WAIT2 and never wraps, because the limit check precedes the increment.
- Latency:
  - long_press rises LONG_LIMIT+1 edges after the first edge that samples in=1.
  - short_press rises DOUBLE_WINDOW+1 edges after the first edge that samples in=0 in PRESS1.
  - double_press rises 1 edge after the release of the second press.
- Input assumption: in is glitch-free (debounced). Single-cycle highs and lows are still handled per the FSM without special-casing.
- Unused/illegal state encodings → IDLE on the next clock.

Test Plan:
Bench parameters for all scenarios: LONG_LIMIT=8, DOUBLE_WINDOW=5, COUNT_SIZE=4; reset pulsed for 2 cycles at start.
- Reset values: assert reset, then hold in=0 for 10 cycles → all pulses 0, held=0, press_count=0, FSM in IDLE.
- Short press: in=1 for 3 cycles, then in=0 for 10 cycles.
  - Exactly one short_press pulse, 6 edges after the release is sampled.
  - press_count=1; no long_press or double_press.
- Long press: in=1 for 20 cycles, then 0.
  - Exactly one long_press pulse, 9 edges after the first high sample.
  - No pulse on release; press_count=1.
- Double press: in=1 ×2, 0 ×3, 1 ×4, 0.
  - One double_press pulse, 1 edge after the second release.
  - No short_press; press_count=2.
- Window boundary: release, then re-press exactly on the edge where timer==4 → PRESS2 taken and double_press follows, no short_press. Re-press one cycle later → short_press fires first, then the new press starts a fresh gesture.
- Wrap and reset: 17 short presses → press_count reads 1 after the 17th. Reset asserted in the middle of PRESS1 → no pulse, press_count=0, and the next press behaves as a fresh gesture.

Source files
------------

// File: rtl/button_event_classifier.sv
// ---------------------------------------------------------------------------
// button_event_classifier
//
// Purpose:
//   Takes the debounced, clock-synchronous button level and turns each
//   gesture into one of three one-cycle events: a short press, a long press
//   or a double press. A single shared timer measures both the hold time of
//   the first press and the gap after a short release. It also exports a
//   registered copy of the level and a wrapping count of presses.
//
// Ports:
//   clock         in   system clock, everything runs on the rising edge
//   reset         in   synchronous active-high reset, beats every other event
//   in            in   debounced button level, 1 = pressed
//   short_press   out  one-cycle pulse, single short press classified
//   long_press    out  one-cycle pulse, press held for LONG_LIMIT cycles
//   double_press  out  one-cycle pulse, second press released inside window
//   held          out  registered copy of in (one cycle late)
//   press_count   out  count of rising edges of in, wraps to zero
// ---------------------------------------------------------------------------
module button_event_classifier #(
    parameter int unsigned                TIMER_SIZE    = 16,
    parameter logic [TIMER_SIZE-1:0]      LONG_LIMIT    = 16'd1000,
    parameter logic [TIMER_SIZE-1:0]      DOUBLE_WINDOW = 16'd300,
    parameter int unsigned                COUNT_SIZE    = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in,
    output logic                  short_press,
    output logic                  long_press,
    output logic                  double_press,
    output logic                  held,
    output logic [COUNT_SIZE-1:0] press_count
);

    // Last timer values before a limit fires. Checking against limit-1
    // before incrementing means the timer never has to reach or pass the
    // limit itself, so it cannot wrap.
    localparam logic [TIMER_SIZE-1:0] LONG_LAST   = TIMER_SIZE'(LONG_LIMIT - 1'b1);
    localparam logic [TIMER_SIZE-1:0] WINDOW_LAST = TIMER_SIZE'(DOUBLE_WINDOW - 1'b1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        LONG_HELD = 3'd2,
        WAIT2     = 3'd3,
        PRESS2    = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [TIMER_SIZE-1:0]   timer_q, timer_d;
    logic                    in_q;
    logic                    shortPress_q, shortPress_d;
    logic                    longPress_q, longPress_d;
    logic                    doublePress_q, doublePress_d;
    logic [COUNT_SIZE-1:0]   pressCount_q, pressCount_d;
    logic                    riseEdge;

    // A press is counted on the same clock its rising edge is seen.
    always_comb begin
        riseEdge     = in & ~in_q;
        pressCount_d = pressCount_q;
        if (riseEdge) begin
            pressCount_d = pressCount_q + COUNT_SIZE'(1);
        end
    end

    // Gesture classifier. Every state change clears the shared timer so
    // each timed state starts counting from zero. Pulses are only decided
    // here and get registered below, so each appears for exactly one cycle.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        shortPress_d  = 1'b0;
        longPress_d   = 1'b0;
        doublePress_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in) begin
                    state_d = PRESS1;
                    timer_d = '0;
                end
            end
            PRESS1: begin
                if (!in) begin
                    state_d = WAIT2;
                    timer_d = '0;
                end else if (timer_q == LONG_LAST) begin
                    longPress_d = 1'b1;
                    state_d     = LONG_HELD;
                    timer_d     = '0;
                end else begin
                    timer_d = timer_q + TIMER_SIZE'(1);
                end
            end
            LONG_HELD: begin
                if (!in) begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            end
            WAIT2: begin
                // A re-press on the very last window cycle still counts as
                // the second press, so the press test comes first.
                if (in) begin
                    state_d = PRESS2;
                    timer_d = '0;
                end else if (timer_q == WINDOW_LAST) begin
                    shortPress_d = 1'b1;
                    state_d      = IDLE;
                    timer_d      = '0;
                end else begin
                    timer_d = timer_q + TIMER_SIZE'(1);
                end
            end
            PRESS2: begin
                // The second press is deliberately not timed.
                if (!in) begin
                    doublePress_d = 1'b1;
                    state_d       = IDLE;
                    timer_d       = '0;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // State, timer, level copy, pulses and counter. Reset abandons any
    // gesture in flight without emitting a pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            in_q          <= 1'b0;
            shortPress_q  <= 1'b0;
            longPress_q   <= 1'b0;
            doublePress_q <= 1'b0;
            pressCount_q  <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            in_q          <= in;
            shortPress_q  <= shortPress_d;
            longPress_q   <= longPress_d;
            doublePress_q <= doublePress_d;
            pressCount_q  <= pressCount_d;
        end
    end

    assign short_press  = shortPress_q;
    assign long_press   = longPress_q;
    assign double_press = doublePress_q;
    assign held         = in_q;
    assign press_count  = pressCount_q;

endmodule

// File: tb/tb_button_event_classifier.sv
// ---------------------------------------------------------------------------
// tb_button_event_classifier
//
// Directed scenarios drive the button level; each scenario queues the
// pulses it expects (kind and the clock edge that registers it). A separate
// monitor pops the queue whenever the DUT raises any pulse. Level outputs
// (held, press_count) are checked directly from the stimulus.
// ---------------------------------------------------------------------------
module tb_button_event_classifier;

    localparam int KIND_SHORT  = 1;
    localparam int KIND_LONG   = 2;
    localparam int KIND_DOUBLE = 3;

    typedef struct {
        int kind;
        int edgeNum;
    } pulse_t;

    logic       clock;
    logic       reset;
    logic       buttonIn;
    logic       shortPress;
    logic       longPress;
    logic       doublePress;
    logic       held;
    logic [3:0] pressCount;

    int     edgeCnt = 0;
    int     checks  = 0;
    int     errors  = 0;
    pulse_t expQ[$];

    button_event_classifier #(
        .TIMER_SIZE    (16),
        .LONG_LIMIT    (16'd8),
        .DOUBLE_WINDOW (16'd5),
        .COUNT_SIZE    (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in           (buttonIn),
        .short_press  (shortPress),
        .long_press   (longPress),
        .double_press (doublePress),
        .held         (held),
        .press_count  (pressCount)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Numbers every rising edge so pulses can be matched to the edge that
    // registered them.
    always @(posedge clock) begin
        edgeCnt <= edgeCnt + 1;
    end

    function automatic string kindName(input int kind);
        case (kind)
            KIND_SHORT:  return "short";
            KIND_LONG:   return "long";
            KIND_DOUBLE: return "double";
            default:     return "none";
        endcase
    endfunction

    // Monitor: on the falling edge, any raised pulse must be the oldest
    // expected one, registered on the expected edge, and alone.
    always @(negedge clock) begin
        int     nPulses;
        int     actKind;
        pulse_t exp;
        nPulses = int'(shortPress) + int'(longPress) + int'(doublePress);
        if (nPulses != 0) begin
            checks++;
            actKind = shortPress ? KIND_SHORT : (longPress ? KIND_LONG : KIND_DOUBLE);
            if (nPulses > 1) begin
                errors++;
                $display("[TB] FAIL pulseOneHot edge %0d: %0d pulses high, required 1",
                         edgeCnt, nPulses);
            end else if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL pulseUnexpected edge %0d: got %s, required none",
                         edgeCnt, kindName(actKind));
            end else begin
                exp = expQ.pop_front();
                if (exp.kind != actKind || exp.edgeNum != edgeCnt) begin
                    errors++;
                    $display("[TB] FAIL pulseMatch: got %s at edge %0d, required %s at edge %0d",
                             kindName(actKind), edgeCnt, kindName(exp.kind), exp.edgeNum);
                end
            end
        end
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives the button level for a number of clocks, changing inputs 1
    // time unit after each rising edge.
    task automatic applyStimulus(input logic level, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            buttonIn = level;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic expectPulse(input int kind, input int edgeNum);
        pulse_t p;
        p.kind    = kind;
        p.edgeNum = edgeNum;
        expQ.push_back(p);
    endtask

    // Every queued pulse must have been seen by the end of a scenario.
    task automatic checkDrained(input string name);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s: %0d expected pulses never seen, required 0",
                     name, expQ.size());
            expQ.delete();
        end
    endtask

    task automatic resetDut(input int cycles);
        reset    = 1'b1;
        buttonIn = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
    endtask

    initial begin
        int base;
        reset    = 1'b1;
        buttonIn = 1'b0;

        // Reset values.
        resetDut(2);
        applyStimulus(1'b0, 10);
        checkOutput("resetHeld", int'(held), 0);
        checkOutput("resetCount", int'(pressCount), 0);
        checkOutput("resetPulses", int'(shortPress) + int'(longPress) + int'(doublePress), 0);
        checkDrained("resetNoPulse");

        // Short press: release sampled at base+4, pulse 6 edges later counting it.
        resetDut(2);
        base = edgeCnt;
        expectPulse(KIND_SHORT, base + 9);
        applyStimulus(1'b1, 3);
        checkOutput("shortHeld", int'(held), 1);
        applyStimulus(1'b0, 10);
        checkOutput("shortCount", int'(pressCount), 1);
        checkOutput("shortHeldLow", int'(held), 0);
        checkDrained("shortDrained");

        // Long press: first high sample at base+1, pulse on base+9.
        resetDut(2);
        base = edgeCnt;
        expectPulse(KIND_LONG, base + 9);
        applyStimulus(1'b1, 20);
        checkOutput("longHeld", int'(held), 1);
        applyStimulus(1'b0, 10);
        checkOutput("longCount", int'(pressCount), 1);
        checkDrained("longDrained");

        // Double press: second release sampled at base+10.
        resetDut(2);
        base = edgeCnt;
        expectPulse(KIND_DOUBLE, base + 10);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 4);
        applyStimulus(1'b0, 10);
        checkOutput("doubleCount", int'(pressCount), 2);
        checkDrained("doubleDrained");

        // Window boundary: re-press sampled with timer at its last value.
        resetDut(2);
        base = edgeCnt;
        expectPulse(KIND_DOUBLE, base + 10);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 5);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 10);
        checkOutput("windowInCount", int'(pressCount), 2);
        checkDrained("windowInDrained");

        // One cycle too late: short first, then a fresh gesture.
        resetDut(2);
        base = edgeCnt;
        expectPulse(KIND_SHORT, base + 8);
        expectPulse(KIND_SHORT, base + 16);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 6);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 10);
        checkOutput("windowOutCount", int'(pressCount), 2);
        checkDrained("windowOutDrained");

        // Counter wrap: 16 presses return a 4-bit count to 0, the 17th gives 1.
        resetDut(2);
        for (int i = 0; i < 17; i++) begin
            base = edgeCnt;
            expectPulse(KIND_SHORT, base + 8);
            applyStimulus(1'b1, 2);
            applyStimulus(1'b0, 8);
            if (i == 15) begin
                checkOutput("wrapCount16", int'(pressCount), 0);
            end
        end
        checkOutput("wrapCount17", int'(pressCount), 1);
        checkDrained("wrapDrained");

        // Reset in the middle of PRESS1 abandons the gesture silently.
        resetDut(2);
        applyStimulus(1'b1, 3);
        reset = 1'b1;
        applyStimulus(1'b1, 2);
        reset = 1'b0;
        applyStimulus(1'b0, 12);
        checkOutput("midResetCount", int'(pressCount), 0);
        checkOutput("midResetHeld", int'(held), 0);
        checkDrained("midResetNoPulse");

        // The following press is classified from scratch.
        base = edgeCnt;
        expectPulse(KIND_SHORT, base + 9);
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 10);
        checkOutput("freshCount", int'(pressCount), 1);
        checkDrained("freshDrained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
